// File: rtl/decode_pkg.sv
// Shared definitions for the decode stage: RV32I base opcodes, immediate
// formats and the bundle of decoded fields held in the pipeline register.
package decode_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_NONE
  } imm_fmt_e;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic        illegal;
  } dec_fields_t;

  // Anything outside the ten base opcodes maps to FMT_NONE, which marks it illegal.
  function automatic imm_fmt_e imm_fmt_of(input logic [6:0] opcode);
    imm_fmt_e fmt;
    case (opcode)
      OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM: fmt = FMT_I;
      OPC_STORE:                                  fmt = FMT_S;
      OPC_BRANCH:                                 fmt = FMT_B;
      OPC_LUI, OPC_AUIPC:                         fmt = FMT_U;
      OPC_JAL:                                    fmt = FMT_J;
      OPC_OP:                                     fmt = FMT_R;
      default:                                    fmt = FMT_NONE;
    endcase
    return fmt;
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational immediate generator: assembles the sign-extended immediate
// for the given instruction format. R-type and illegal words yield zero.
module imm_gen
  import decode_pkg::*;
(
  input  logic [31:0] insn_i,
  input  imm_fmt_e    fmt_i,
  output logic [31:0] imm_o
);

  // The opcode bits never contribute to an immediate.
  logic unused_opcode;
  assign unused_opcode = ^insn_i[6:0];

  always_comb begin
    imm_o = '0;
    case (fmt_i)
      FMT_I:   imm_o = {{20{insn_i[31]}}, insn_i[31:20]};
      FMT_S:   imm_o = {{20{insn_i[31]}}, insn_i[31:25], insn_i[11:7]};
      FMT_B:   imm_o = {{19{insn_i[31]}}, insn_i[31], insn_i[7], insn_i[30:25],
                        insn_i[11:8], 1'b0};
      FMT_U:   imm_o = {insn_i[31:12], 12'b0};
      FMT_J:   imm_o = {{11{insn_i[31]}}, insn_i[31], insn_i[19:12], insn_i[20],
                        insn_i[30:21], 1'b0};
      default: imm_o = '0;
    endcase
  end

endmodule

// File: rtl/decode.sv
// RV32I decode stage: a single valid/ready pipeline register that captures the
// fetched instruction and its fully decoded fields, with flush for redirects.
module decode
  import decode_pkg::*;
#(
  parameter int              DWIDTH   = 32,
  parameter int              AWIDTH   = 32,
  parameter logic [AWIDTH-1:0] BASEADDR = AWIDTH'(32'h01000000)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AWIDTH-1:0] pc_i,
  input  logic [DWIDTH-1:0] insn_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic              flush_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [AWIDTH-1:0] pc_o,
  output logic [DWIDTH-1:0] insn_o,
  output logic [6:0]        opcode_o,
  output logic [4:0]        rd_o,
  output logic [4:0]        rs1_o,
  output logic [4:0]        rs2_o,
  output logic [2:0]        funct3_o,
  output logic [6:0]        funct7_o,
  output logic [31:0]       imm_o,
  output logic              illegal_o
);

  logic              valid_q, valid_d;
  logic [AWIDTH-1:0] pc_q, pc_d;
  logic [DWIDTH-1:0] insn_q, insn_d;
  dec_fields_t       fields_q, fields_d;

  imm_fmt_e    fmt;
  logic [31:0] imm;
  logic        accept;

  assign fmt = imm_fmt_of(insn_i[6:0]);

  imm_gen u_imm_gen (
    .insn_i (insn_i[31:0]),
    .fmt_i  (fmt),
    .imm_o  (imm)
  );

  assign ready_o = !valid_q || ready_i;
  assign accept  = valid_i && ready_o && !flush_i;

  // Flush wins over capture and hold; payload is only loaded on accept.
  always_comb begin
    valid_d  = valid_q;
    pc_d     = pc_q;
    insn_d   = insn_q;
    fields_d = fields_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d          = 1'b1;
      pc_d             = pc_i;
      insn_d           = insn_i;
      fields_d.opcode  = insn_i[6:0];
      fields_d.rd      = insn_i[11:7];
      fields_d.rs1     = insn_i[19:15];
      fields_d.rs2     = insn_i[24:20];
      fields_d.funct3  = insn_i[14:12];
      fields_d.funct7  = insn_i[31:25];
      fields_d.imm     = imm;
      fields_d.illegal = (fmt == FMT_NONE);
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      pc_q     <= BASEADDR;
      insn_q   <= '0;
      fields_q <= '0;
    end else begin
      valid_q  <= valid_d;
      pc_q     <= pc_d;
      insn_q   <= insn_d;
      fields_q <= fields_d;
    end
  end

  assign valid_o   = valid_q;
  assign pc_o      = pc_q;
  assign insn_o    = insn_q;
  assign opcode_o  = fields_q.opcode;
  assign rd_o      = fields_q.rd;
  assign rs1_o     = fields_q.rs1;
  assign rs2_o     = fields_q.rs2;
  assign funct3_o  = fields_q.funct3;
  assign funct7_o  = fields_q.funct7;
  assign imm_o     = fields_q.imm;
  assign illegal_o = fields_q.illegal;

endmodule

// File: tb/tb_decode.sv
// Scoreboard bench for the decode stage: expected decodes are queued when an
// instruction is accepted and compared when the stage hands it downstream.
module tb_decode;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_i;
  logic [31:0] insn_i;
  logic        valid_i;
  logic        flush_i;
  logic        ready_i;
  logic        ready_o;
  logic        valid_o;
  logic [31:0] pc_o;
  logic [31:0] insn_o;
  logic [6:0]  opcode_o;
  logic [4:0]  rd_o;
  logic [4:0]  rs1_o;
  logic [4:0]  rs2_o;
  logic [2:0]  funct3_o;
  logic [6:0]  funct7_o;
  logic [31:0] imm_o;
  logic        illegal_o;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
    logic [31:0] imm;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        illegal;
  } exp_t;

  exp_t obs;
  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  assign obs = {pc_o, insn_o, imm_o, opcode_o, rd_o, rs1_o, rs2_o,
                funct3_o, funct7_o, illegal_o};

  always #5 clk = ~clk;

  decode dut (
    .clk       (clk),
    .rst       (rst),
    .pc_i      (pc_i),
    .insn_i    (insn_i),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .flush_i   (flush_i),
    .ready_i   (ready_i),
    .valid_o   (valid_o),
    .pc_o      (pc_o),
    .insn_o    (insn_o),
    .opcode_o  (opcode_o),
    .rd_o      (rd_o),
    .rs1_o     (rs1_o),
    .rs2_o     (rs2_o),
    .funct3_o  (funct3_o),
    .funct7_o  (funct7_o),
    .imm_o     (imm_o),
    .illegal_o (illegal_o)
  );

  // Reference decode built from arithmetic shifts of the whole word.
  function automatic exp_t ref_decode(input logic [31:0] pc, input logic [31:0] insn);
    exp_t               e;
    logic signed [31:0] s;
    logic [31:0]        sx;
    s = insn;
    e = '0;
    e.pc     = pc;
    e.insn   = insn;
    e.opcode = insn[6:0];
    e.rd     = insn[11:7];
    e.rs1    = insn[19:15];
    e.rs2    = insn[24:20];
    e.funct3 = insn[14:12];
    e.funct7 = insn[31:25];
    case (insn[6:0])
      7'h13, 7'h03, 7'h67, 7'h73: e.imm = s >>> 20;
      7'h23: begin
        sx = s >>> 25;
        e.imm = (sx << 5) | {27'b0, insn[11:7]};
      end
      7'h63: begin
        sx = s >>> 31;
        e.imm = (sx << 12) | ({31'b0, insn[7]} << 11) | ({26'b0, insn[30:25]} << 5)
              | ({28'b0, insn[11:8]} << 1);
      end
      7'h37, 7'h17: e.imm = insn & 32'hFFFFF000;
      7'h6F: begin
        sx = s >>> 31;
        e.imm = (sx << 20) | ({24'b0, insn[19:12]} << 12) | ({31'b0, insn[20]} << 11)
              | ({22'b0, insn[30:21]} << 1);
      end
      7'h33: e.imm = 32'h0;
      default: begin
        e.imm     = 32'h0;
        e.illegal = 1'b1;
      end
    endcase
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; valid_i = 1'b0; flush_i = 1'b0; ready_i = 1'b0;
    pc_i = 32'h0; insn_i = 32'h0;
    step();
    step();
    rst = 1'b0;
    #1;
    checks++;
    if (valid_o !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_valid got %0b want 0", valid_o);
    end
    checks++;
    if (pc_o !== 32'h01000000) begin
      errors++; $display("[TB] FAIL reset_pc got %h want 01000000", pc_o);
    end
    checks++;
    if ({insn_o, imm_o, opcode_o, rd_o, rs1_o, rs2_o, funct3_o, funct7_o, illegal_o} !== '0) begin
      errors++; $display("[TB] FAIL reset_fields got %h want 0", obs);
    end
    checks++;
    if (ready_o !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_ready got %0b want 1", ready_o);
    end
  endtask

  task automatic test_addi();
    exp_t e;
    valid_i = 1'b1; pc_i = 32'h01000000; insn_i = 32'h00500093; ready_i = 1'b1;
    #1;
    checks++;
    if (ready_o !== 1'b1) begin
      errors++; $display("[TB] FAIL addi_ready got %0b want 1", ready_o);
    end
    sb_q.push_back(ref_decode(pc_i, insn_i));
    step();
    valid_i = 1'b0;
    checks++;
    if (valid_o !== 1'b1) begin
      errors++; $display("[TB] FAIL addi_valid got %0b want 1", valid_o);
    end
    e = sb_q.pop_front();
    checks++;
    if (obs !== e) begin
      errors++; $display("[TB] FAIL addi_fields got %h want %h", obs, e);
    end
    checks++;
    if ({opcode_o, rd_o, rs1_o, imm_o, pc_o} !== {7'h13, 5'd1, 5'd0, 32'h5, 32'h01000000}) begin
      errors++;
      $display("[TB] FAIL addi_const got op=%h rd=%0d rs1=%0d imm=%h pc=%h want op=13 rd=1 rs1=0 imm=00000005 pc=01000000",
               opcode_o, rd_o, rs1_o, imm_o, pc_o);
    end
    step();
    checks++;
    if (valid_o !== 1'b0) begin
      errors++; $display("[TB] FAIL addi_drain got %0b want 0", valid_o);
    end
  endtask

  task automatic test_formats();
    logic [31:0] ins  [6] = '{32'hFE112E23, 32'hFE000CE3, 32'h123452B7,
                              32'h010000EF, 32'h00000000, 32'h00000033};
    logic [31:0] imms [6] = '{32'hFFFFFFFC, 32'hFFFFFFF8, 32'h12345000,
                              32'h00000010, 32'h00000000, 32'h00000000};
    logic        ills [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    exp_t e;
    ready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      valid_i = 1'b1;
      insn_i  = ins[i];
      pc_i    = 32'h01000100 + 32'(i * 4);
      sb_q.push_back(ref_decode(pc_i, insn_i));
      step();
      e = sb_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++; $display("[TB] FAIL fmt%0d_fields got %h want %h", i, obs, e);
      end
      checks++;
      if ({imm_o, illegal_o} !== {imms[i], ills[i]}) begin
        errors++;
        $display("[TB] FAIL fmt%0d_imm got imm=%h ill=%0b want imm=%h ill=%0b",
                 i, imm_o, illegal_o, imms[i], ills[i]);
      end
    end
    valid_i = 1'b0;
    step();
  endtask

  task automatic test_back_to_back_stall();
    exp_t a, b;
    valid_i = 1'b1; insn_i = 32'h00A10113; pc_i = 32'h01000200; ready_i = 1'b1;
    sb_q.push_back(ref_decode(pc_i, insn_i));
    step();
    a = sb_q[0];
    insn_i = 32'h00C000EF; pc_i = 32'h01000204; ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if ({valid_o, ready_o, obs} !== {1'b1, 1'b0, a}) begin
        errors++;
        $display("[TB] FAIL stall%0d got v=%0b r=%0b %h want v=1 r=0 %h",
                 k, valid_o, ready_o, obs, a);
      end
    end
    ready_i = 1'b1;
    #1;
    checks++;
    if (ready_o !== 1'b1) begin
      errors++; $display("[TB] FAIL release_ready got %0b want 1", ready_o);
    end
    a = sb_q.pop_front();
    checks++;
    if (obs !== a) begin
      errors++; $display("[TB] FAIL release_handoff got %h want %h", obs, a);
    end
    sb_q.push_back(ref_decode(pc_i, insn_i));
    step();
    valid_i = 1'b0;
    b = sb_q.pop_front();
    checks++;
    if ({valid_o, obs} !== {1'b1, b}) begin
      errors++; $display("[TB] FAIL release_next got v=%0b %h want v=1 %h", valid_o, obs, b);
    end
    step();
    checks++;
    if (valid_o !== 1'b0) begin
      errors++; $display("[TB] FAIL release_drain got %0b want 0", valid_o);
    end
  endtask

  task automatic test_flush();
    valid_i = 1'b1; insn_i = 32'h00100113; pc_i = 32'h01000300; ready_i = 1'b1;
    step();
    insn_i = 32'h00200193; pc_i = 32'h01000304; ready_i = 1'b0; flush_i = 1'b1;
    step();
    flush_i = 1'b0; valid_i = 1'b0;
    checks++;
    if (valid_o !== 1'b0) begin
      errors++; $display("[TB] FAIL flush_valid got %0b want 0", valid_o);
    end
    step();
    checks++;
    if (valid_o !== 1'b0) begin
      errors++; $display("[TB] FAIL flush_after got %0b want 0", valid_o);
    end
  endtask

  task automatic test_reset_stall();
    valid_i = 1'b1; insn_i = 32'h00500093; pc_i = 32'h01000400; ready_i = 1'b1;
    step();
    valid_i = 1'b0; ready_i = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    checks++;
    if ({valid_o, pc_o, ready_o, insn_o} !== {1'b0, 32'h01000000, 1'b1, 32'h0}) begin
      errors++;
      $display("[TB] FAIL rst_stall got v=%0b pc=%h r=%0b insn=%h want v=0 pc=01000000 r=1 insn=0",
               valid_o, pc_o, ready_o, insn_o);
    end
    sb_q.delete();
  endtask

  task automatic test_random();
    logic [6:0]  opcs [11] = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63,
                               7'h37, 7'h17, 7'h6F, 7'h33, 7'h0B};
    logic [31:0] tmp;
    logic        mvalid;
    logic        rdy;
    logic        acc;
    exp_t        e;
    mvalid = 1'b0;
    for (int c = 0; c < 300; c++) begin
      valid_i = ($urandom_range(0, 3) != 0);
      ready_i = ($urandom_range(0, 3) != 0);
      flush_i = ($urandom_range(0, 15) == 0);
      tmp     = $urandom;
      insn_i  = {tmp[31:7], opcs[$urandom_range(0, 10)]};
      pc_i    = $urandom;
      #1;
      rdy = !mvalid || ready_i;
      checks++;
      if (ready_o !== rdy) begin
        errors++; $display("[TB] FAIL rand%0d_ready got %0b want %0b", c, ready_o, rdy);
      end
      if (mvalid && flush_i) begin
        void'(sb_q.pop_front());
      end else if (mvalid && ready_i) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++; $display("[TB] FAIL rand%0d_empty got output want none", c);
        end else begin
          e = sb_q.pop_front();
          if (obs !== e) begin
            errors++; $display("[TB] FAIL rand%0d_fields got %h want %h", c, obs, e);
          end
        end
      end
      acc = valid_i && rdy && !flush_i;
      if (acc) sb_q.push_back(ref_decode(pc_i, insn_i));
      mvalid = flush_i ? 1'b0 : (acc ? 1'b1 : (ready_i ? 1'b0 : mvalid));
      step();
      checks++;
      if (valid_o !== mvalid) begin
        errors++; $display("[TB] FAIL rand%0d_valid got %0b want %0b", c, valid_o, mvalid);
      end
    end
    valid_i = 1'b0; flush_i = 1'b0; ready_i = 1'b1;
    step();
    sb_q.delete();
  endtask

  initial begin
    test_reset();
    test_addi();
    test_formats();
    test_back_to_back_stall();
    test_flush();
    test_reset_stall();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode.md
DECODE -- requirements
Module: decode

Interface
REQ-001 Parameter DWIDTH, default 32, instruction width in bits.
REQ-002 Parameter AWIDTH, default 32, program-counter width in bits.
REQ-003 Parameter BASEADDR, default 32'h01000000, reset value of pc_o.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 pc_i  input  AWIDTH  PC of the incoming instruction, from fetch.
REQ-007 insn_i  input  DWIDTH  incoming instruction word, from fetch.
REQ-008 valid_i  input  1  pc_i/insn_i valid this cycle.
REQ-009 ready_o  output  1  decode can accept an instruction this cycle.
REQ-010 flush_i  input  1  discard the held and incoming instruction (redirect).
REQ-011 ready_i  input  1  downstream stage accepts the output this cycle.
REQ-012 valid_o  output  1  decoded outputs valid.
REQ-013 pc_o  output  AWIDTH  registered PC of the decoded instruction.
REQ-014 insn_o  output  DWIDTH  registered raw instruction.
REQ-015 opcode_o  output  7  insn[6:0].
REQ-016 rd_o, rs1_o, rs2_o  output  5 each  insn[11:7], insn[19:15], insn[24:20].
REQ-017 funct3_o  output  3  insn[14:12]; funct7_o  output  7  insn[31:25].
REQ-018 imm_o  output  32  sign-extended immediate for the instruction format.
REQ-019 illegal_o  output  1  instruction is not a recognised RV32I opcode.

Function
REQ-020 Single pipeline register stage; latency exactly 1 cycle from accepted input to valid_o.
REQ-021 ready_o SHALL equal (!valid_o || ready_i), combinational, with no dependence on valid_i.
REQ-022 Accept (register capture) occurs iff valid_i && ready_o && !flush_i; next cycle valid_o=1.
REQ-023 valid_o && !ready_i: all outputs hold stable, with no change, until ready_i.
REQ-024 ready_i && valid_o && no accept: valid_o clears next cycle.
REQ-025 flush_i SHALL have priority over accept and hold: next cycle valid_o=0, and the incoming instruction is dropped.
REQ-026 Immediate formats: I (opcodes 0010011, 0000011, 1100111, 1110011) = sext(insn[31:20]); S (0100011) = sext({insn[31:25],insn[11:7]}); B (1100011) = sext({insn[31],insn[7],insn[30:25],insn[11:8],1'b0}); U (0110111, 0010111) = {insn[31:12],12'b0}; J (1101111) = sext({insn[31],insn[19:12],insn[20],insn[30:21],1'b0}); R (0110011) and illegal = 0.
REQ-027 illegal_o=1 iff opcode is not one of the ten listed above, including insn[1:0]!=2'b11.
REQ-028 All decoded fields SHALL be computed from insn_i at capture and registered, with no combinational path from insn_i to any output.
REQ-029 Output fields while valid_o=0 are don't-care except after reset (REQ-030).

Reset
REQ-030 When rst=1 at a rising edge: valid_o=0, pc_o=BASEADDR, insn_o=0, all decoded fields=0, imm_o=0, illegal_o=0; rst overrides flush_i and accept.
REQ-031 Reset mid-stall SHALL discard the held instruction; ready_o=1 on the first cycle after reset.

Structure
REQ-032 Shared package decode_pkg SHALL hold the opcode localparams and an imm_fmt_e enum (R, I, S, B, U, J, NONE).
REQ-033 The combinational sub-module imm_gen (insn in, format in, imm out) SHALL be instantiated once inside decode.

Verification
REQ-034 Accept insn_i=32'h00500093 (addi x1,x0,5), pc_i=32'h01000000, ready_i=1 -> next cycle valid_o=1, opcode_o=7'h13, rd_o=1, rs1_o=0, imm_o=32'h00000005, pc_o=32'h01000000.
REQ-035 Format sweep: insn 32'hFE112E23 -> imm_o=32'hFFFFFFFC, rs1_o=2, rs2_o=1; insn 32'hFE000CE3 -> imm_o=32'hFFFFFFF8; insn 32'h123452B7 -> imm_o=32'h12345000, rd_o=5; insn 32'h010000EF -> imm_o=32'h00000010, rd_o=1.
REQ-036 Backpressure: hold ready_i=0 for 3 cycles while valid_o=1 -> outputs unchanged, ready_o=0, and the new valid_i is not captured; with ready_i=1 the held instruction leaves and the next one is captured in the same cycle.
REQ-037 Flush: flush_i=1 together with valid_i=1 and valid_o=1 -> next cycle valid_o=0, and neither instruction appears on the output.
REQ-038 insn_i=32'h00000000 -> illegal_o=1, imm_o=0; insn_i=32'h00000033 (add) -> illegal_o=0, imm_o=0.
REQ-039 rst asserted during a stall -> next cycle valid_o=0, pc_o=32'h01000000, ready_o=1.
